// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the common data bus arbiter.
//   nzcv_t        : condition flags carried with a result
//   cdb_packet_t  : one result as it sits in a holding slot and as it is broadcast
//   slot_state_t  : occupancy state of a per-FU holding slot
package cdb_arbiter_pkg;

  localparam int CDB_NUM_FU   = 3;
  localparam int ROB_IDX_SIZE = 6;
  localparam int GPR_SIZE     = 32;

  typedef logic [3:0] nzcv_t;

  typedef struct packed {
    logic [ROB_IDX_SIZE-1:0] rob_index;
    logic [GPR_SIZE-1:0]     value;
    logic                    set_nzcv;
    nzcv_t                   nzcv;
    logic                    is_mispred;
  } cdb_packet_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // Width of an index into n entries; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Bundle between the functional units and the CDB arbiter.
//   in_fu_*      : per-FU result handshake, driven by the FUs (master)
//   out_fu_ready : per-FU slot availability, driven by the arbiter (slave)
//   out_cdb_*    : registered broadcast toward the ROB and reservation stations
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU = CDB_NUM_FU
) ();

  localparam int SRC_W = idx_width(NUM_FU);

  logic [NUM_FU-1:0]              in_fu_done;
  logic [NUM_FU*ROB_IDX_SIZE-1:0] in_fu_dst_rob_index;
  logic [NUM_FU*GPR_SIZE-1:0]     in_fu_value;
  logic [NUM_FU-1:0]              in_fu_set_nzcv;
  logic [NUM_FU*4-1:0]            in_fu_nzcv;
  logic [NUM_FU-1:0]              in_fu_is_mispred;

  logic [NUM_FU-1:0]              out_fu_ready;

  logic                           out_cdb_valid;
  logic [ROB_IDX_SIZE-1:0]        out_cdb_rob_index;
  logic [GPR_SIZE-1:0]            out_cdb_value;
  logic                           out_cdb_set_nzcv;
  nzcv_t                          out_cdb_nzcv;
  logic                           out_cdb_is_mispred;
  logic [SRC_W-1:0]               out_cdb_src;

  modport master (
    output in_fu_done, in_fu_dst_rob_index, in_fu_value,
           in_fu_set_nzcv, in_fu_nzcv, in_fu_is_mispred,
    input  out_fu_ready,
           out_cdb_valid, out_cdb_rob_index, out_cdb_value,
           out_cdb_set_nzcv, out_cdb_nzcv, out_cdb_is_mispred, out_cdb_src
  );

  modport slave (
    input  in_fu_done, in_fu_dst_rob_index, in_fu_value,
           in_fu_set_nzcv, in_fu_nzcv, in_fu_is_mispred,
    output out_fu_ready,
           out_cdb_valid, out_cdb_rob_index, out_cdb_value,
           out_cdb_set_nzcv, out_cdb_nzcv, out_cdb_is_mispred, out_cdb_src
  );

endinterface

// File: rtl/cdb_arbiter_rr.sv
// Combinational round-robin picker: the first set request at or above ptr,
// wrapping modulo N. The pointer register lives in the caller.
//   req         : request vector
//   ptr         : index with highest priority this cycle
//   grant_valid : some request is set
//   grant_idx   : index of the winning request
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          grant_valid,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] cand;

  // Walk the offsets from farthest to nearest so the nearest requester,
  // being assigned last, wins without needing an early exit.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr) + k) % N);
      if (req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Shares the common data bus among NUM_FU functional units. Each FU drops a
// finished result into a private one-entry slot; a round-robin scheduler
// picks one full slot per cycle and registers it onto the CDB broadcast.
//   in_clk   : core clock
//   in_rst   : synchronous reset, active high
//   in_flush : mispredict flush, empties every slot and drops same-cycle results
//   bus      : FU result inputs, per-FU ready, CDB broadcast outputs
//
// Slot FSM (one per FU)
//   state      | meaning
//   SLOT_EMPTY | no result held; FU may deliver
//   SLOT_FULL  | result waiting for a grant; FU may deliver only in the grant cycle
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU = CDB_NUM_FU
) (
  input logic          in_clk,
  input logic          in_rst,
  input logic          in_flush,
  cdb_arbiter_if.slave bus
);

  localparam int SRC_W = idx_width(NUM_FU);

  slot_state_t      slot_state [NUM_FU];
  slot_state_t      slot_next  [NUM_FU];
  cdb_packet_t      slot_pkt   [NUM_FU];
  cdb_packet_t      fu_pkt     [NUM_FU];

  logic [NUM_FU-1:0] full;
  logic [NUM_FU-1:0] gnt_vec;
  logic [NUM_FU-1:0] ready;
  logic [NUM_FU-1:0] load;
  logic              grant_valid;
  logic [SRC_W-1:0]  grant_idx;
  logic [SRC_W-1:0]  ptr;

  cdb_packet_t       cdb_q;
  logic              cdb_valid_q;
  logic [SRC_W-1:0]  cdb_src_q;

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      fu_pkt[i]            = '0;
      fu_pkt[i].rob_index  = bus.in_fu_dst_rob_index[i*ROB_IDX_SIZE +: ROB_IDX_SIZE];
      fu_pkt[i].value      = bus.in_fu_value[i*GPR_SIZE +: GPR_SIZE];
      fu_pkt[i].set_nzcv   = bus.in_fu_set_nzcv[i];
      fu_pkt[i].nzcv       = bus.in_fu_nzcv[i*4 +: 4];
      fu_pkt[i].is_mispred = bus.in_fu_is_mispred[i];
      full[i]              = (slot_state[i] == SLOT_FULL);
    end
  end

  rr_arbiter #(.N(NUM_FU)) u_rr (
    .req         (full),
    .ptr         (ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // A slot being granted this cycle frees up at the edge, so it can take a
  // new result at the same edge; that is what lets one FU stream uncontended.
  always_comb begin
    gnt_vec = '0;
    if (grant_valid) gnt_vec[grant_idx] = 1'b1;
    ready = (in_rst || in_flush) ? '0 : (~full | gnt_vec);
    load  = bus.in_fu_done & ready;
    for (int i = 0; i < NUM_FU; i++) begin
      slot_next[i] = slot_state[i];
      if (in_flush)        slot_next[i] = SLOT_EMPTY;
      else if (load[i])    slot_next[i] = SLOT_FULL;
      else if (gnt_vec[i]) slot_next[i] = SLOT_EMPTY;
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      for (int i = 0; i < NUM_FU; i++) slot_state[i] <= SLOT_EMPTY;
      ptr         <= '0;
      cdb_valid_q <= 1'b0;
      cdb_q       <= '0;
      cdb_src_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) slot_state[i] <= slot_next[i];
      if (in_flush) begin
        // Pointer is deliberately held across a flush.
        cdb_valid_q <= 1'b0;
      end else if (grant_valid) begin
        cdb_valid_q <= 1'b1;
        cdb_q       <= slot_pkt[grant_idx];
        cdb_src_q   <= grant_idx;
        ptr         <= (grant_idx == SRC_W'(NUM_FU - 1)) ? '0 : grant_idx + SRC_W'(1);
      end else begin
        cdb_valid_q <= 1'b0;
      end
    end
  end

  // Payload needs no reset: it is only observed while its slot is FULL.
  always_ff @(posedge in_clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (load[i]) slot_pkt[i] <= fu_pkt[i];
    end
  end

  assign bus.out_fu_ready       = ready;
  assign bus.out_cdb_valid      = cdb_valid_q;
  assign bus.out_cdb_rob_index  = cdb_q.rob_index;
  assign bus.out_cdb_value      = cdb_q.value;
  assign bus.out_cdb_set_nzcv   = cdb_q.set_nzcv;
  assign bus.out_cdb_nzcv       = cdb_q.nzcv;
  assign bus.out_cdb_is_mispred = cdb_q.is_mispred;
  assign bus.out_cdb_src        = cdb_src_q;

  // An FU must not deliver into a slot that is still waiting for its grant.
  // Reset and flush drop inputs by definition, so they are exempt.
  a_done_needs_ready: assert property (
    @(posedge in_clk) disable iff (in_rst || in_flush)
      (bus.in_fu_done & ~ready) == '0
  );

endmodule
